// File: rtl/cache_nway.sv
// cache_nway: parametrised set-associative, write-back, write-allocate cache
// with tree pseudo-LRU replacement and a 256-bit line port to memory.
// Optional macro CACHE_PERF_CNT_EN adds hit/miss/write-back counters
// (perf_hit, perf_miss, perf_wb).
module cache_nway #(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   mem_address,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [31:0]   mem_byte_enable,
   input  logic [255:0]  mem_wdata,
   output logic [255:0]  mem_rdata,
   output logic          mem_resp,
   output logic [31:0]   pmem_address,
   output logic          pmem_read,
   output logic          pmem_write,
   input  logic [255:0]  pmem_rdata,
   output logic [255:0]  pmem_wdata,
`ifdef CACHE_PERF_CNT_EN
   output logic [31:0]   perf_hit,
   output logic [31:0]   perf_miss,
   output logic [31:0]   perf_wb,
`endif
   input  logic          pmem_resp
);

   localparam int unsigned LINE_W = 256;
   localparam int unsigned BYTES  = 32;
   localparam int unsigned OFF_W  = 5;
   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
   localparam int unsigned NODES  = WAYS - 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_COMPARE   = 2'd1;
   localparam logic [1:0] S_WRITEBACK = 2'd2;
   localparam logic [1:0] S_ALLOCATE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [WAY_W-1:0]  victim_q;

   logic [LINE_W-1:0] data_q  [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [NODES-1:0]  plru_q  [SETS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic              req;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  victim_way;
   logic [LINE_W-1:0] merged_line;
   logic              addr_unused;

   assign idx         = mem_address[OFF_W +: IDX_W];
   assign req_tag     = mem_address[31 -: TAG_W];
   assign req         = mem_read | mem_write;
   assign addr_unused = ^mem_address[OFF_W-1:0];

   // Walk the PLRU tree from the root to the way it points at.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
      int unsigned      node;
      logic [NODES-1:0] sh;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         sh   = bits >> node;
         node = 2 * node + 1 + 32'(sh[0]);
      end
      return WAY_W'(node - NODES);
   endfunction

   // Point every node on the path to a way away from that way.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
      int unsigned      node;
      logic [WAY_W-1:0] wsh;
      logic [NODES-1:0] mask;
      logic [NODES-1:0] res;
      res  = bits;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         wsh  = way >> (WAY_W - 1 - l);
         mask = NODES'(1) << node;
         if (wsh[0]) res = res & ~mask;
         else        res = res | mask;
         node = 2 * node + 1 + 32'(wsh[0]);
      end
      return res;
   endfunction

   // Tag lookup and victim choice (lowest invalid way, else PLRU).
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      victim_way = plru_victim(plru_q[idx]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][WAY_W'(w)]) victim_way = WAY_W'(w);
      end
   end

   // Byte-masked merge of the write data into the hit line.
   always_comb begin
      merged_line = data_q[idx][hit_way];
      for (int b = 0; b < BYTES; b++) begin
         if (mem_byte_enable[5'(b)]) merged_line[8'(8 * b) +: 8] = mem_wdata[8'(8 * b) +: 8];
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (hit) begin
               mem_resp  = 1'b1;
               mem_rdata = data_q[idx][hit_way];
               state_d   = S_IDLE;
            end else if (dirty_q[idx][victim_way]) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[idx][victim_q], idx, 5'b0};
            pmem_wdata   = data_q[idx][victim_q];
            if (pmem_resp) state_d = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, idx, 5'b0};
            if (pmem_resp) state_d = S_COMPARE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, victim latch and valid/dirty/PLRU metadata.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         victim_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            S_COMPARE: begin
               if (req && hit) begin
                  plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                  if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
               end else if (req) begin
                  victim_q <= victim_way;
               end
            end
            S_WRITEBACK: begin
               if (pmem_resp) dirty_q[idx][victim_q] <= 1'b0;
            end
            S_ALLOCATE: begin
               if (pmem_resp) begin
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Line data and tags; never cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state_q == S_COMPARE) && mem_write && hit) begin
            data_q[idx][hit_way] <= merged_line;
         end
         if ((state_q == S_ALLOCATE) && pmem_resp) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= req_tag;
         end
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic        fill_q;
   logic [31:0] perf_hit_q, perf_miss_q, perf_wb_q;

   // Event counters; the COMPARE right after a fill is not a real hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q      <= 1'b0;
         perf_hit_q  <= '0;
         perf_miss_q <= '0;
         perf_wb_q   <= '0;
      end else begin
         if ((state_q == S_ALLOCATE) && pmem_resp) fill_q <= 1'b1;
         else if (state_q == S_COMPARE)            fill_q <= 1'b0;
         if ((state_q == S_COMPARE) && req) begin
            if (hit && !fill_q) perf_hit_q  <= perf_hit_q + 32'd1;
            else if (!hit)      perf_miss_q <= perf_miss_q + 32'd1;
         end
         if ((state_q == S_WRITEBACK) && pmem_resp) perf_wb_q <= perf_wb_q + 32'd1;
      end
   end

   assign perf_hit  = perf_hit_q;
   assign perf_miss = perf_miss_q;
   assign perf_wb   = perf_wb_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway (WAYS=4, SETS=8) with a 10-cycle memory model.
module tb_cache_nway;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_byte_enable;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_rdata = '0;
   logic [255:0] pmem_wdata;
   logic         pmem_resp = 1'b0;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0]  perf_hit, perf_miss, perf_wb;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_nway #(.WAYS(4), .SETS(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .pmem_address    (pmem_address),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_rdata      (pmem_rdata),
      .pmem_wdata      (pmem_wdata),
`ifdef CACHE_PERF_CNT_EN
      .perf_hit        (perf_hit),
      .perf_miss       (perf_miss),
      .perf_wb         (perf_wb),
`endif
      .pmem_resp       (pmem_resp)
   );

   // Memory model: default line is the line address repeated, overridden by write-backs.
   int unsigned  mcnt = 0;
   int           nrd = 0, nwr = 0, ev_seq = 1, rd_seq = 0, wr_seq = 0;
   logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
   logic [255:0] last_wr_data = '0;
   logic [31:0]  wb_addr [8];
   logic [255:0] wb_data [8];
   int           wb_n = 0;
   logic         both_hi = 1'b0;

   function automatic logic [255:0] model_line(input logic [31:0] a);
      logic [255:0] d;
      d = {8{a}};
      for (int i = 0; i < 8; i++) begin
         if (i < wb_n && wb_addr[i] == a) d = wb_data[i];
      end
      return d;
   endfunction

   always @(posedge clk) begin
      pmem_resp <= 1'b0;
      if (pmem_read && pmem_write) both_hi <= 1'b1;
      if (rst) begin
         mcnt <= 0;
      end else if ((pmem_read || pmem_write) && !pmem_resp) begin
         if (mcnt == 9) begin
            mcnt      <= 0;
            pmem_resp <= 1'b1;
            ev_seq    <= ev_seq + 1;
            if (pmem_write) begin
               nwr          <= nwr + 1;
               wr_seq       <= ev_seq;
               last_wr_addr <= pmem_address;
               last_wr_data <= pmem_wdata;
               if (wb_n < 8) begin
                  wb_addr[wb_n[2:0]] <= pmem_address;
                  wb_data[wb_n[2:0]] <= pmem_wdata;
                  wb_n               <= wb_n + 1;
               end
            end else begin
               nrd          <= nrd + 1;
               rd_seq       <= ev_seq;
               last_rd_addr <= pmem_address;
               pmem_rdata   <= model_line(pmem_address);
            end
         end else begin
            mcnt <= mcnt + 1;
         end
      end else begin
         mcnt <= 0;
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One request held until mem_resp; lat counts edges up to the completing edge.
   task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] be,
                         input logic [255:0] wd, output logic [255:0] rd, output int lat);
      int   n;
      logic done;
      @(negedge clk);
      mem_address     = a;
      mem_read        = !wr;
      mem_write       = wr;
      mem_byte_enable = be;
      mem_wdata       = wd;
      n    = 0;
      done = 1'b0;
      rd   = '0;
      while (!done && n < 400) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (mem_resp) begin
            rd   = mem_rdata;
            done = 1'b1;
         end
      end
      if (done) begin
         @(posedge clk);
         n++;
      end
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      lat = done ? n : -1;
      if (!done) check("access_timeout", 256'(done), 256'(1));
   endtask

   initial begin
      logic [255:0] rd;
      int           lat, r0, w0, seen;
      logic [31:0]  full;
      full            = 32'hffff_ffff;
      rst             = 1'b1;
      mem_address     = '0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = '0;
      mem_wdata       = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_resp",  256'(mem_resp),   256'(0));
      check("rst_mem_rdata", mem_rdata,        256'(0));
      check("rst_pmem_read", 256'(pmem_read),  256'(0));
      check("rst_pmem_wr",   256'(pmem_write), 256'(0));
      check("rst_pmem_addr", 256'(pmem_address), 256'(0));
      rst = 1'b0;

      // Cold miss then repeat hit
      r0 = nrd; w0 = nwr;
      access(32'h4000_8000, 1'b0, '0, '0, rd, lat);
      check("cold_rd_cnt",  256'(nrd - r0), 256'(1));
      check("cold_rd_addr", 256'(last_rd_addr), 256'(32'h4000_8000));
      check("cold_wr_cnt",  256'(nwr - w0), 256'(0));
      check("cold_data",    rd, {8{32'h4000_8000}});
      access(32'h4000_8000, 1'b0, '0, '0, rd, lat);
      check("hit_latency",  256'(lat), 256'(2));
      check("hit_no_pmem",  256'(nrd - r0), 256'(1));
      check("hit_data",     rd, {8{32'h4000_8000}});

      // PLRU eviction in set 2
      do_reset();
      r0 = nrd; w0 = nwr;
      access(32'h4000_8042, 1'b0, '0, '0, rd, lat);
      access(32'h4001_8042, 1'b0, '0, '0, rd, lat);
      access(32'h4002_8042, 1'b0, '0, '0, rd, lat);
      access(32'h4003_8042, 1'b0, '0, '0, rd, lat);
      check("fill4_data",   rd, {8{32'h4003_8040}});
      access(32'h4000_8042, 1'b0, '0, '0, rd, lat);
      check("plru_hit_lat", 256'(lat), 256'(2));
      check("plru_hit_data", rd, {8{32'h4000_8040}});
      access(32'h4004_8042, 1'b0, '0, '0, rd, lat);
      check("evict_rd_cnt",  256'(nrd - r0), 256'(5));
      check("evict_rd_addr", 256'(last_rd_addr), 256'(32'h4004_8040));
      check("evict_no_wb",   256'(nwr - w0), 256'(0));
      check("evict_data",    rd, {8{32'h4004_8040}});
`ifdef CACHE_PERF_CNT_EN
      check("perf_hit",  256'(perf_hit),  256'(1));
      check("perf_miss", 256'(perf_miss), 256'(5));
      check("perf_wb",   256'(perf_wb),   256'(0));
`endif
      access(32'h4002_8042, 1'b0, '0, '0, rd, lat);
      check("victim_miss_cnt",  256'(nrd - r0), 256'(6));
      check("victim_miss_addr", 256'(last_rd_addr), 256'(32'h4002_8040));
      access(32'h4003_8042, 1'b0, '0, '0, rd, lat);
      check("survivor_hit_lat", 256'(lat), 256'(2));

      // Dirty write-back
      do_reset();
      r0 = nrd; w0 = nwr;
      access(32'h4000_8042, 1'b1, full, 256'hf111, rd, lat);
      access(32'h4001_8042, 1'b1, full, 256'hf222, rd, lat);
      access(32'h4002_8042, 1'b1, full, 256'hf333, rd, lat);
      access(32'h4003_8042, 1'b1, full, 256'hf444, rd, lat);
      check("wr_no_wb", 256'(nwr - w0), 256'(0));
      access(32'h4004_8042, 1'b1, full, 256'hf555, rd, lat);
      check("wb_cnt",       256'(nwr - w0), 256'(1));
      check("wb_addr",      256'(last_wr_addr), 256'(32'h4000_8040));
      check("wb_data",      last_wr_data, 256'hf111);
      check("wb_fill_cnt",  256'(nrd - r0), 256'(5));
      check("wb_fill_addr", 256'(last_rd_addr), 256'(32'h4004_8040));
      check("wb_then_fill", 256'(wr_seq < rd_seq), 256'(1));
      access(32'h4004_8042, 1'b0, '0, '0, rd, lat);
      check("wr_hit_data", rd, 256'hf555);
      check("wr_hit_lat",  256'(lat), 256'(2));
      access(32'h4000_8042, 1'b0, '0, '0, rd, lat);
      check("wb_refetch_data", rd, 256'hf111);
      check("wb2_addr",        256'(last_wr_addr), 256'(32'h4002_8040));
      check("wb2_data",        last_wr_data, 256'hf333);

      // Byte enable, then force eviction to observe dirty merged line
      w0 = nwr;
      access(32'h4005_0000, 1'b1, full, 256'h1111, rd, lat);
      access(32'h4005_0000, 1'b1, 32'h0000_0001, {256{1'b1}}, rd, lat);
      access(32'h4005_0000, 1'b0, '0, '0, rd, lat);
      check("be_data", rd, 256'h11ff);
      access(32'h4006_0000, 1'b0, '0, '0, rd, lat);
      access(32'h4007_0000, 1'b0, '0, '0, rd, lat);
      access(32'h4008_0000, 1'b0, '0, '0, rd, lat);
      check("be_no_wb_yet", 256'(nwr - w0), 256'(0));
      access(32'h4009_0000, 1'b0, '0, '0, rd, lat);
      check("be_wb_cnt",  256'(nwr - w0), 256'(1));
      check("be_wb_addr", 256'(last_wr_addr), 256'(32'h4005_0000));
      check("be_wb_data", last_wr_data, 256'h11ff);

      // Reset during a fill
      @(negedge clk);
      mem_address = 32'h400a_0000;
      mem_read    = 1'b1;
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1;
      end
      check("fill_started", 256'(seen), 256'(1));
      r0 = nrd;
      rst      = 1'b1;
      mem_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_pmem_read", 256'(pmem_read),  256'(0));
      check("midrst_pmem_wr",   256'(pmem_write), 256'(0));
      check("midrst_mem_resp",  256'(mem_resp),   256'(0));
      check("midrst_no_fill",   256'(nrd - r0),   256'(0));
      rst = 1'b0;
      access(32'h400a_0000, 1'b0, '0, '0, rd, lat);
      check("post_rst_miss", 256'(nrd - r0), 256'(1));
      check("post_rst_data", rd, {8{32'h400a_0000}});

      check("never_rd_and_wr", 256'(both_hi), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised set-associative, write-back, write-allocate cache.
- Sits between a single CPU-side requester (one line-wide read/write port) and physical memory (one 256-bit line port).
- Successor to the fixed 4-way/8-set cache: way count and set count are generics; replacement is tree pseudo-LRU; victim choice prefers invalid ways.
- Line size fixed at 256 bits (32 bytes); address 32 bits.

Parameters:
- WAYS, 4, associativity; power of two, 2..16.
- SETS, 8, sets per way; power of two, 2..256. Index = mem_address[5 +: log2(SETS)]; tag = remaining upper bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_address  in  32  CPU byte address; bits [4:0] ignored.
- mem_read  in  1  read request; held until mem_resp.
- mem_write  in  1  write request; held until mem_resp.
- mem_byte_enable  in  32  per-byte write mask for mem_wdata.
- mem_wdata  in  256  write line data.
- mem_rdata  out  256  hit line data; valid only while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned address; bits [4:0]=0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line write-back request; held until pmem_resp.
- pmem_rdata  in  256  fill data; sampled when pmem_resp=1.
- pmem_wdata  out  256  victim line data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Storage is flop-based per set/way: tag, valid, dirty, 256-bit data, plus WAYS-1 PLRU bits per set.
- Reset:
  - State goes to IDLE.
  - All valid, dirty and PLRU bits are cleared.
  - All outputs are 0; data/tag arrays are not cleared.
- IDLE:
  - On mem_read|mem_write, go to COMPARE next cycle.
  - If both are asserted, the write takes priority (illegal stimulus, but defined).
- COMPARE:
  - Hit (valid and tag match in any way) asserts mem_resp this cycle and returns to IDLE. Hit latency is 2 cycles from the edge that samples the request.
  - On a read hit, mem_rdata is the hit way's line.
  - On a write hit, each data byte i is replaced by mem_wdata byte i where mem_byte_enable[i]=1, and dirty is set.
  - Every hit updates PLRU.
- COMPARE miss, victim selection:
  - Victim is the lowest-index invalid way; otherwise the PLRU victim.
  - Dirty victim goes to WRITEBACK; clean victim goes to ALLOCATE.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line.
  - On pmem_resp, clear dirty and go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, index, 5'b0}.
  - On pmem_resp, write pmem_rdata, tag, valid=1, dirty=0, then go to COMPARE, which then hits.
  - A miss therefore costs one extra COMPARE cycle after the fill.
- PLRU is a binary tree, node 0 at the root with children 2n+1 and 2n+2.
  - Node bit 0 means the victim is in the left (lower-index) subtree.
  - Accessing a way sets each node on its path to point away from it.
  - All-zero bits select way 0 as victim.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- pmem_read and pmem_write are never high together, and never change mid-transaction.
- Reset during WRITEBACK/ALLOCATE:
  - The transaction is abandoned and pmem_read/pmem_write are 0 from the next cycle.
  - Dirty data is lost.
- Requester must hold address, data and mask stable until mem_resp; the cache does not register them.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, three 32-bit output ports are added: perf_hit, perf_miss, perf_wb.
  - perf_hit counts COMPARE hits, excluding the post-fill COMPARE.
  - perf_miss counts COMPARE misses.
  - perf_wb counts completed write-backs.
  - All three reset to 0 and wrap at 2^32.
- When undefined, the ports and counter logic are absent and behaviour is otherwise identical.

Test Plan (WAYS=4, SETS=8, memory model responds after 10 cycles):
- Cold miss: read 0x40008000 -> one pmem_read at 0x40008000, no pmem_write, mem_rdata = model line. Repeat read -> mem_resp 2 cycles after request, no pmem activity.
- PLRU eviction: read index-2 lines 0x40008042, 0x40018042, 0x40028042, 0x40038042, then 0x40008042 (hit), then 0x40048042 -> fill evicts way 2 (0x40028042), no pmem_write. Re-reading 0x40028042 misses, pmem_read at 0x40028040.
- Dirty write-back: full-mask writes 0xf111/0xf222/0xf333/0xf444 to 0x40008042..0x40038042, then write 0xf555 to 0x40048042 -> pmem_write at 0x40008040 with data 0xf111, then pmem_read at 0x40048040. Reading 0x40008042 later returns 0xf111.
- Byte enable: line holds 0x1111; write mask 0x00000001, wdata all-ones -> read returns 0x11ff, dirty set.
- Reset mid-fill: assert rst while pmem_read=1 -> pmem_read=0 next cycle, mem_resp=0. Subsequent read of the same address misses again.
- With CACHE_PERF_CNT_EN, after the eviction scenario -> perf_hit=1, perf_miss=5, perf_wb=0.
